pipeline_ctrl: RTL and testbench

Central stall/flush/halt controller for the 5-stage RISC-V pipeline. Every cycle it drives the write enables and bubble-insert selects for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Conditions handled: load-use hazards, taken branches, multi-cycle data-memory waits, and debug halt/drain requests. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt controller for the 5-stage pipeline: per-cycle register enables and bubble
// selects, debug drain/halt sequencing, saturating event counters and a memory-timeout flag.
module pipeline_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q;
  logic [2:0]       drain_cnt_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             mem_wait;
  logic             load_use;
  logic             stall_inc;
  logic             flush_inc;

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign stall_inc = (state_q != StHalted) & (mem_wait | (load_use & ~ex_branch_taken));
  assign flush_inc = (state_q != StHalted) & ex_branch_taken & ~mem_wait;

  // Controls are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst && state_q != StHalted) begin
      if (mem_wait) begin
        mem_wb_we    = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_we    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
      end else begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        id_ex_we  = 1'b1;
        ex_mem_we = 1'b1;
        mem_wb_we = 1'b1;
      end
      // Draining stops fetch but still captures a redirect target.
      if (state_q == StDrain && !mem_wait) begin
        pc_we       = ex_branch_taken;
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= 3'd0;
      halted      <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt_req) begin
            state_q     <= StDrain;
            drain_cnt_q <= 3'd4;
          end
        end
        StDrain: begin
          if (!halt_req) begin
            state_q <= StRun;
          end else if (!mem_wait && !load_use) begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
            if (drain_cnt_q == 3'd1) begin
              state_q <= StHalted;
              halted  <= 1'b1;
            end
          end
        end
        StHalted: begin
          if (!halt_req) begin
            state_q <= StRun;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_q <= StRun;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt_q != WaitW'(MEM_TIMEOUT)) wait_cnt_q <= wait_cnt_q + WaitW'(1);
      if (wait_cnt_q >= WaitW'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model queues the expected outputs per
// cycle, and a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b1;
  logic rst, halt_req, mem_req, mem_ready, ex_branch_taken, ex_mem_read;
  logic id_uses_rs1, id_uses_rs2;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  // we = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, mem_wb}
  typedef struct packed {
    logic [4:0]    we;
    logic [2:0]    fl;
    logic          halted;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
    logic          tmo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_frozen, m_draining, m_tmo;
  int m_left, m_stall, m_flush, m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_enables", {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 32'(e.we));
        chk("flushes", {29'd0, if_id_flush, id_ex_flush, mem_wb_flush}, 32'(e.fl));
        chk("halted", 32'(halted), 32'(e.halted));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.flush));
        chk("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
      end
    end
  end

  // Apply one cycle of inputs, queue the expected response, advance the model, then the clock.
  task automatic cyc(input bit r, input bit h, input bit mreq, input bit mrdy, input bit br,
                     input bit lr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input bit u1, input bit u2);
    exp_t e;
    bit mw, lu;
    rst = r; halt_req = h; mem_req = mreq; mem_ready = mrdy; ex_branch_taken = br;
    ex_mem_read = lr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    mw = mreq && !mrdy;
    lu = lr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e = '0;
    if (r) begin
      exp_q.push_back(e);
      m_frozen = 0; m_draining = 0; m_tmo = 0;
      m_left = 0; m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      e.stall = CW'(m_stall); e.flush = CW'(m_flush); e.tmo = m_tmo; e.halted = m_frozen;
      if (!m_frozen) begin
        if (mw)       begin e.we = 5'b00001; e.fl = 3'b001; end
        else if (br)  begin e.we = 5'b11111; e.fl = 3'b110; end
        else if (lu)  begin e.we = 5'b00111; e.fl = 3'b010; end
        else          begin e.we = 5'b11111; e.fl = 3'b000; end
        if (m_draining && !mw) begin e.we[4] = br; e.we[3] = 1'b1; e.fl[2] = 1'b1; end
      end
      exp_q.push_back(e);
      if (!m_frozen) begin
        if (mw || (lu && !br)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (br && !mw) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end
      if (mw) begin
        m_wait = (m_wait < TMO) ? m_wait + 1 : TMO;
        if (m_wait >= TMO) m_tmo = 1;
      end else begin
        m_wait = 0;
      end
      if (m_frozen) begin
        if (!h) m_frozen = 0;
      end else if (m_draining) begin
        if (!h) m_draining = 0;
        else if (!mw && !lu) begin
          m_left--;
          if (m_left == 0) begin m_draining = 0; m_frozen = 1; end
        end
      end else if (h) begin
        m_draining = 1; m_left = 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit h;
    int slow;
    h = 0;
    slow = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use stall, then the same with x0 as destination
    cyc(0, 0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    // Branch together with load-use
    cyc(0, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    // Three wait cycles holding a branch, then ready
    repeat (3) cyc(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Five-cycle wait trips the timeout
    repeat (5) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Drain, halt, release
    repeat (7) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a drain
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) slow = $urandom_range(0, 2);
      if ($urandom_range(0, 39) == 0) h = !h;
      cyc(bit'($urandom_range(0, 299) == 0), h, bit'($urandom_range(0, 1)),
          bit'(slow == 0 ? $urandom_range(0, 7) != 0 :
               slow == 1 ? $urandom_range(0, 1) : $urandom_range(0, 7) == 0),
          bit'($urandom_range(0, 6) == 0), bit'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
